// File: rtl/sha256_pkg.sv
// ---------------------------------------------------------------------------
// sha256_pkg
// Shared SHA-256 types, constants and the small sigma functions used by the
// message schedule. The compression core imports the same package, so both
// sides agree on the word type and the sigma definitions.
//   word_t         : 32-bit SHA-256 word
//   SHA_ROUNDS     : schedule words emitted per block
//   SCHED_WIN      : depth of the sliding schedule window
//   sched_state_t  : message-schedule FSM states
// ---------------------------------------------------------------------------
package sha256_pkg;

    typedef logic [31:0] word_t;

    localparam int SHA_ROUNDS = 64;
    localparam int SCHED_WIN  = 16;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } sched_state_t;

    // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
    function automatic word_t sigma0(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
    function automatic word_t sigma1(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

endpackage

// File: rtl/sha256_sched_word.sv
// ---------------------------------------------------------------------------
// sha256_sched_word
// Purely combinational generator of the next schedule word from four taps of
// the sliding window. Kept separate so an unrolled schedule can instantiate
// several copies.
// Ports:
//   w0  : W[t-16]  (window slot 0)
//   w1  : W[t-15]  (window slot 1)
//   w9  : W[t-7]   (window slot 9)
//   w14 : W[t-2]   (window slot 14)
//   wn  : W[t] = sigma1(w14) + w9 + sigma0(w1) + w0, mod 2^32
// ---------------------------------------------------------------------------
module sha256_sched_word
    import sha256_pkg::*;
(
    input  logic [31:0] w0,
    input  logic [31:0] w1,
    input  logic [31:0] w9,
    input  logic [31:0] w14,
    output logic [31:0] wn
);

    assign wn = sigma1(w14) + w9 + sigma0(w1) + w0;

endmodule

// File: rtl/sha256_message_schedule.sv
// ---------------------------------------------------------------------------
// sha256_message_schedule
// Accepts one 512-bit message block and streams the 64 schedule words
// W[0..63] to the compression core, one word per valid/ready handshake.
// A 16-word window holds W[t..t+15]; slot 0 is the word on offer and each
// accepted handshake shifts the window down with the freshly computed word
// entering slot 15.
//
// Ports:
//   clk        : system clock
//   n_rst      : synchronous reset, active HIGH (priority over restart)
//   load       : capture block_in and start streaming (only while load_ready)
//   block_in   : message block, [511:480]=W[0] ... [31:0]=W[15]
//   restart    : abort current block, back to IDLE (priority over load/handshake)
//   load_ready : idle and able to accept load
//   w_valid    : w_out/w_index carry a valid word
//   w_ready    : compression core consumes the word this cycle
//   w_out      : current schedule word W[w_index]
//   w_index    : index t of w_out, 0..63
//   done       : one-cycle pulse after W[63] is accepted
//
// Build option:
//   MSCHED_BYTESWAP_EN : when defined, every 32-bit input word is
//                        byte-reversed at capture (little-endian headers).
// ---------------------------------------------------------------------------
module sha256_message_schedule
    import sha256_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  load,
    input  logic [16*WORD_W-1:0]  block_in,
    input  logic                  restart,
    output logic                  load_ready,
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic [WORD_W-1:0]     w_out,
    output logic [5:0]            w_index,
    output logic                  done
);

    localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

    sched_state_t state;
    word_t        win [SCHED_WIN];
    word_t        wn;

    function automatic word_t capture_word(input word_t x);
`ifdef MSCHED_BYTESWAP_EN
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
        return x;
`endif
    endfunction

    sha256_sched_word u_sched_word (
        .w0  (win[0]),
        .w1  (win[1]),
        .w9  (win[9]),
        .w14 (win[14]),
        .wn  (wn)
    );

    // All outputs decode directly from the state register, so they are glitch
    // free and change only on the clock edge.
    assign load_ready = (state == IDLE);
    assign w_valid    = (state == STREAM);
    assign done       = (state == DONE);
    assign w_out      = win[0];

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state   <= IDLE;
            w_index <= '0;
            for (int i = 0; i < SCHED_WIN; i++) begin
                win[i] <= '0;
            end
        end else if (restart) begin
            state   <= IDLE;
            w_index <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        for (int i = 0; i < SCHED_WIN; i++) begin
                            win[i] <= capture_word(block_in[(SCHED_WIN-1-i)*WORD_W +: WORD_W]);
                        end
                        w_index <= '0;
                        state   <= STREAM;
                    end
                end
                STREAM: begin
                    if (w_ready) begin
                        // The last word holds index and window: nothing is
                        // offered after W[63], so no shift is needed.
                        if (w_index == LAST_IDX) begin
                            state <= DONE;
                        end else begin
                            for (int i = 0; i < SCHED_WIN - 1; i++) begin
                                win[i] <= win[i+1];
                            end
                            win[SCHED_WIN-1] <= wn;
                            w_index          <= w_index + 6'd1;
                        end
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    w_index <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
